// File: rtl/operand_fetch.sv
// Operand fetch stage: drives register file read ports, tracks in-flight writes per
// register to stall on RAW/WAW hazards, bypasses same-cycle writeback, registers operands for execute.
module operand_fetch #(
  parameter int REG_WIDTH  = 5,
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INFO_W     = 64,
  parameter int PEND_W     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_rs_en,
  input  logic [REG_WIDTH-1:0]  in_rs_addr,
  input  logic                  in_rt_en,
  input  logic [REG_WIDTH-1:0]  in_rt_addr,
  input  logic                  in_rd_en,
  input  logic [REG_WIDTH-1:0]  in_rd_addr,
  input  logic [INFO_W-1:0]     in_info,
  output logic                  rs_en,
  output logic [REG_WIDTH-1:0]  rs_addr,
  input  logic [DATA_WIDTH-1:0] rs_data,
  output logic                  rt_en,
  output logic [REG_WIDTH-1:0]  rt_addr,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  wb_en,
  input  logic [REG_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs_val,
  output logic [DATA_WIDTH-1:0] out_rt_val,
  output logic                  out_rd_en,
  output logic [REG_WIDTH-1:0]  out_rd_addr,
  output logic [INFO_W-1:0]     out_info
);

  localparam int PW1 = PEND_W + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0]     pending   [REG_NUM];
  logic [PEND_W-1:0]     pend_next [REG_NUM];
  logic [PW1-1:0]        up;
  logic [1:0]            down;
  logic                  rs_haz, rt_haz, waw_haz, hazard, xfer;
  logic [DATA_WIDTH-1:0] rs_val, rt_val;

  assign rs_en   = in_rs_en;
  assign rs_addr = in_rs_addr;
  assign rt_en   = in_rt_en;
  assign rt_addr = in_rt_addr;

  // Source resolution: zero register, writeback bypass, hazard, or register file value
  always_comb begin
    rs_val  = {DATA_WIDTH{1'b0}};
    rt_val  = {DATA_WIDTH{1'b0}};
    rs_haz  = 1'b0;
    rt_haz  = 1'b0;
    waw_haz = 1'b0;
    if (!in_rs_en || in_rs_addr == {REG_WIDTH{1'b0}}) begin
      rs_val = {DATA_WIDTH{1'b0}};
    end else if (wb_en && wb_addr == in_rs_addr && pending[in_rs_addr] == PEND_ONE) begin
      rs_val = wb_data;
    end else if (pending[in_rs_addr] != {PEND_W{1'b0}}) begin
      rs_haz = 1'b1;
    end else begin
      rs_val = rs_data;
    end
    if (!in_rt_en || in_rt_addr == {REG_WIDTH{1'b0}}) begin
      rt_val = {DATA_WIDTH{1'b0}};
    end else if (wb_en && wb_addr == in_rt_addr && pending[in_rt_addr] == PEND_ONE) begin
      rt_val = wb_data;
    end else if (pending[in_rt_addr] != {PEND_W{1'b0}}) begin
      rt_haz = 1'b1;
    end else begin
      rt_val = rt_data;
    end
    // A saturated counter cannot take another write unless one retires this cycle
    if (in_rd_en && in_rd_addr != {REG_WIDTH{1'b0}} && pending[in_rd_addr] == PEND_MAX
        && !(wb_en && wb_addr == in_rd_addr)) begin
      waw_haz = 1'b1;
    end else begin
      waw_haz = 1'b0;
    end
  end

  assign hazard   = rs_haz | rt_haz | waw_haz;
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;

  // Scoreboard next state: issue increments, writeback and flush revert decrement, clamped at zero
  always_comb begin
    up   = {PW1{1'b0}};
    down = 2'd0;
    pend_next[0] = {PEND_W{1'b0}};
    for (int r = 1; r < REG_NUM; r++) begin
      up = {1'b0, pending[r]}
         + ((xfer && in_rd_en && in_rd_addr == REG_WIDTH'(r)) ? PW1'(1) : PW1'(0));
      down = ((wb_en && wb_addr == REG_WIDTH'(r) && pending[r] != {PEND_W{1'b0}}) ? 2'd1 : 2'd0)
           + ((flush && out_valid && out_rd_en && out_rd_addr == REG_WIDTH'(r)) ? 2'd1 : 2'd0);
      if (up < PW1'(down)) begin
        pend_next[r] = {PEND_W{1'b0}};
      end else begin
        pend_next[r] = PEND_W'(up - PW1'(down));
      end
    end
  end

  // Scoreboard state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < REG_NUM; r++) pending[r] <= {PEND_W{1'b0}};
    end else begin
      for (int r = 0; r < REG_NUM; r++) pending[r] <= pend_next[r];
    end
  end

  // Output stage: capture on transfer, drop on accept or flush, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_rs_val  <= {DATA_WIDTH{1'b0}};
      out_rt_val  <= {DATA_WIDTH{1'b0}};
      out_rd_en   <= 1'b0;
      out_rd_addr <= {REG_WIDTH{1'b0}};
      out_info    <= {INFO_W{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (xfer) begin
      out_valid   <= 1'b1;
      out_rs_val  <= rs_val;
      out_rt_val  <= rt_val;
      out_rd_en   <= in_rd_en;
      out_rd_addr <= in_rd_addr;
      out_info    <= in_info;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: expected outputs are queued when an accepted
// instruction is driven and compared when execute takes it.
module tb_operand_fetch;

  typedef struct packed {
    logic [31:0] rs;
    logic [31:0] rt;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [63:0] info;
  } exp_t;

  logic        clk, reset, flush;
  logic        in_valid, in_ready;
  logic        in_rs_en, in_rt_en, in_rd_en;
  logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
  logic [63:0] in_info;
  logic        rs_en, rt_en;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs_val, out_rt_val;
  logic        out_rd_en;
  logic [4:0]  out_rd_addr;
  logic [63:0] out_info;

  logic [31:0] rf [32];
  exp_t        q [$];
  int          tests = 0;
  int          fails = 0;
  int          total;

  assign rs_data = rf[rs_addr];
  assign rt_data = rf[rt_addr];

  operand_fetch dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_en(in_rs_en), .in_rs_addr(in_rs_addr),
    .in_rt_en(in_rt_en), .in_rt_addr(in_rt_addr),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr), .in_info(in_info),
    .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(rs_data),
    .rt_en(rt_en), .rt_addr(rt_addr), .rt_data(rt_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_info(out_info)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic re, input logic [4:0] ra,
                       input logic te, input logic [4:0] ta,
                       input logic de, input logic [4:0] da, input logic [63:0] inf);
    in_valid = v; in_rs_en = re; in_rs_addr = ra; in_rt_en = te; in_rt_addr = ta;
    in_rd_en = de; in_rd_addr = da; in_info = inf;
  endtask

  // One cycle: check readiness and output handshake at negedge, then advance past posedge
  task automatic tick(input logic exp_rdy, input logic [31:0] ers, input logic [31:0] ert);
    exp_t e;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    chk("rs_addr_pass", {59'd0, rs_addr}, {59'd0, in_rs_addr});
    if (flush) begin
      if (q.size() > 0) q.delete(0);
    end else if (out_valid && out_ready) begin
      chk("q_nonempty", {63'd0, (q.size() > 0)}, 64'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_rs_val", {32'd0, out_rs_val}, {32'd0, e.rs});
        chk("out_rt_val", {32'd0, out_rt_val}, {32'd0, e.rt});
        chk("out_rd", {58'd0, out_rd_en, out_rd_addr}, {58'd0, e.rd_en, e.rd_addr});
        chk("out_info", out_info, e.info);
      end
    end
    if (in_valid && exp_rdy) q.push_back('{ers, ert, in_rd_en, in_rd_addr, in_info});
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[3] = 32'h11; rf[4] = 32'h22;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    #12;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_rs_val", {32'd0, out_rs_val}, 64'd0);
    chk("rst_out_info", out_info, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain fetch from register file
    drive(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0, 64'hA1);
    tick(1'b1, 32'h11, 32'h22);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk("lat1_out_valid", {63'd0, out_valid}, 64'd1);
    tick(1'b1, 32'd0, 32'd0);

    // RAW stall on rd=5, released by same-cycle writeback bypass
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 64'hA2);
    tick(1'b1, 32'd0, 32'd0);
    drive(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 64'hA3);
    tick(1'b0, 32'd0, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
    tick(1'b1, 32'hABCD, 32'd0);
    wb_en = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk("pend5_clear", {62'd0, dut.pending[5]}, 64'd0);
    tick(1'b1, 32'd0, 32'd0);

    // Register zero reads as zero, and rd=0 leaves the scoreboard empty
    rf[0] = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 64'hA4);
    tick(1'b1, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    total = 0;
    for (int r = 0; r < 32; r++) total += int'(dut.pending[r]);
    chk("pend_total_zero", 64'(total), 64'd0);
    tick(1'b1, 32'd0, 32'd0);

    // Backpressure: outputs hold, then back-to-back transfer without a bubble
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 64'hB1);
    tick(1'b1, 32'h11, 32'd0);
    drive(1'b1, 1'b1, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0, 64'hB2);
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 32'd0, 32'd0);
      chk("hold_rs_val", {32'd0, out_rs_val}, 64'h11);
      chk("hold_info", out_info, 64'hB1);
    end
    out_ready = 1'b1;
    tick(1'b1, 32'h22, 32'h11);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk("no_bubble_valid", {63'd0, out_valid}, 64'd1);
    tick(1'b1, 32'd0, 32'd0);

    // WAW limit: three writes to r7 saturate, fourth waits for a writeback
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 64'hC1);
    tick(1'b1, 32'd0, 32'd0);
    tick(1'b1, 32'd0, 32'd0);
    tick(1'b1, 32'd0, 32'd0);
    chk("pend7_sat", {62'd0, dut.pending[7]}, 64'd3);
    tick(1'b0, 32'd0, 32'd0);
    tick(1'b0, 32'd0, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    tick(1'b1, 32'd0, 32'd0);
    wb_en = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk("pend7_after", {62'd0, dut.pending[7]}, 64'd3);
    tick(1'b1, 32'd0, 32'd0);

    // Flush reverts the held instruction's scoreboard increment
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 64'hD1);
    tick(1'b1, 32'd0, 32'd0);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    chk("pend9_held", {62'd0, dut.pending[9]}, 64'd1);
    flush = 1'b1;
    tick(1'b0, 32'd0, 32'd0);
    flush = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("pend9_revert", {62'd0, dut.pending[9]}, 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 64'hE1);
    tick(1'b1, 32'h11, 32'd0);
    drive(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 64'hE2);
    tick(1'b0, 32'd0, 32'd0);
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_pend7", {62'd0, dut.pending[7]}, 64'd0);
    chk("async_rst_info", out_info, 64'd0);
    q.delete();
    drive(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-side initiator for the register file read ports (rs/rt). Accepts one decoded instruction per cycle over a valid/ready handshake and drives the register file read addresses.
- Resolves read-after-write hazards with a per-register pending-write scoreboard, and bypasses same-cycle writeback data.
- Presents the resolved operands to execute through a registered valid/ready output stage.
- Sits between decode and execute. The writeback bus drives both the register file write port and this block.

Parameters:
- REG_WIDTH, 5, register address width.
- REG_NUM, 32, number of architectural registers.
- DATA_WIDTH, 32, operand width.
- INFO_W, 64, width of the opaque decoded-instruction payload passed through.
- PEND_W, 2, width of each scoreboard counter; at most 2^PEND_W-1 writes in flight per register.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard the instruction held in the output stage.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  block accepts the instruction this cycle.
- in_rs_en  in  1  instruction reads rs.
- in_rs_addr  in  REG_WIDTH  rs index.
- in_rt_en  in  1  instruction reads rt.
- in_rt_addr  in  REG_WIDTH  rt index.
- in_rd_en  in  1  instruction writes rd.
- in_rd_addr  in  REG_WIDTH  rd index.
- in_info  in  INFO_W  passthrough payload.
- rs_en  out  1  register file read enable; equals in_rs_en.
- rs_addr  out  REG_WIDTH  register file read address; equals in_rs_addr.
- rs_data  in  DATA_WIDTH  register file combinational read data.
- rt_en  out  1  register file read enable; equals in_rt_en.
- rt_addr  out  REG_WIDTH  register file read address; equals in_rt_addr.
- rt_data  in  DATA_WIDTH  register file combinational read data.
- wb_en  in  1  writeback valid; written into the register file at this clock edge.
- wb_addr  in  REG_WIDTH  writeback index.
- wb_data  in  DATA_WIDTH  writeback value.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute accepts.
- out_rs_val  out  DATA_WIDTH  resolved rs operand.
- out_rt_val  out  DATA_WIDTH  resolved rt operand.
- out_rd_en  out  1  registered in_rd_en.
- out_rd_addr  out  REG_WIDTH  registered in_rd_addr.
- out_info  out  INFO_W  registered in_info.

Behaviour:
- Reset (asynchronous):
  - out_valid=0.
  - All out_* data fields=0.
  - All pending[] counters=0.
- Read ports are combinational pass-through of the in_* source fields, regardless of in_valid.
- Source resolution, per source s in {rs, rt}; the first matching rule applies:
  1. en=0 or addr=0 -> value 0, no hazard.
  2. wb_en and wb_addr==addr and pending[addr]==1 -> value wb_data, no hazard (same-cycle bypass).
  3. pending[addr]!=0 -> hazard.
  4. Otherwise -> value rs_data/rt_data.
- WAW limit: hazard also asserts if in_rd_en, in_rd_addr!=0 and pending[in_rd_addr]==2^PEND_W-1, unless a writeback to that register occurs in the same cycle.
- Ready condition: in_ready = !flush && !hazard && (!out_valid || out_ready). in_ready does not depend on in_valid.
- Transfer occurs when in_valid && in_ready. At that clock edge:
  - The output stage captures the resolved operands, rd_en, rd_addr and info.
  - out_valid<=1.
- Output stage behaviour:
  - Latency from transfer to out_valid is 1 cycle.
  - When out_valid && out_ready and there is no new transfer, out_valid<=0.
  - While out_valid && !out_ready, all out_* fields hold stable.
  - Back-to-back throughput is 1 instruction per cycle.
- Scoreboard, per register r!=0, each cycle:
  - +1 if a transfer occurs with in_rd_en && in_rd_addr==r.
  - -1 if wb_en && wb_addr==r.
  - A simultaneous increment and decrement leaves the counter unchanged.
  - pending[0] is always 0.
  - wb_en to a register whose counter is 0 is ignored; the counter does not underflow.
- Flush:
  - At the edge, out_valid<=0.
  - If the held instruction was valid, had out_rd_en=1 and out_rd_addr!=0, its scoreboard increment is reverted (-1), combined with any same-cycle writeback decrement.
  - in_ready=0 during flush; no transfer occurs.
  - Instructions already past the output stage are not affected; they retire normally through wb.
- Operands are sampled only at transfer. Writebacks occurring after capture do not modify the held out_rs_val/out_rt_val. This is correct because a hazard would have stalled the instruction.

Test Plan:
- Reset, then in_valid with rs=3, rt=4, regfile returning 0x11/0x22, no pending writes -> in_ready=1; next cycle out_valid=1, out_rs_val=0x11, out_rt_val=0x22.
- Issue rd=5, then issue rs=5 with no writeback -> in_ready=0 (stall). Then wb_en=1, wb_addr=5, wb_data=0xABCD -> same cycle in_ready=1; next cycle out_rs_val=0xABCD; pending[5]=0.
- rs_addr=0 with rs_data forced to 0xFFFF_FFFF -> out_rs_val=0; instruction with rd=0 -> scoreboard unchanged.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_* stable. Then out_ready=1 with in_valid=1 -> new data appears next cycle with no bubble.
- Issue three writes to rd=7 (PEND_W=2) -> pending[7]=3. A fourth write to rd=7 stalls until wb_addr=7 arrives, then is accepted; pending[7]=3.
- Held instruction with rd=9 and pending[9]=1; assert flush -> next cycle out_valid=0, pending[9]=0. Assert reset mid-stall -> out_valid=0 and all counters 0 immediately, without waiting for a clock edge.
